// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single data-memory port between two masters with round-robin
// arbitration; each transaction walks IDLE -> ISSUE -> RESP and out-of-range words answer with err.
module dmem_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_WORDS = 1000
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    output logic              m0_rsp_err,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              m1_rsp_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_write,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_read
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] MemLimit = ADDR_W'(MEM_WORDS);

    state_e            state_q, state_d;
    logic              lastGrant_q;
    logic              owner_q;
    logic              we_q;
    logic              inRange_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              memWrite_q;
    logic              memRead_q;
    logic              rspValid_q;
    logic              rspErr_q;
    logic [DATA_W-1:0] rspRdata_q;

    logic              m0Grant;
    logic              m1Grant;
    logic              accept;
    logic              acceptOwner;
    logic              reqWe;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;
    logic              reqInRange;

    // lastGrant_q = 1 means master 1 won the previous accept, so master 0 wins the next tie
    always_comb begin
        m0Grant = 1'b0;
        m1Grant = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            m0Grant = lastGrant_q;
            m1Grant = !lastGrant_q;
        end else begin
            m0Grant = m0_req_valid;
            m1Grant = m1_req_valid;
        end
    end

    always_comb begin
        acceptOwner = m1Grant;
        reqWe       = acceptOwner ? m1_req_we    : m0_req_we;
        reqAddr     = acceptOwner ? m1_req_addr  : m0_req_addr;
        reqWdata    = acceptOwner ? m1_req_wdata : m0_req_wdata;
        reqInRange  = (reqAddr < MemLimit);
        accept      = (m0_req_valid && m0_req_ready) || (m1_req_valid && m1_req_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        if (state_q == IDLE) begin
            m0_req_ready = m0Grant;
            m1_req_ready = m1Grant;
        end
        m0_rsp_valid = rspValid_q && !owner_q;
        m1_rsp_valid = rspValid_q && owner_q;
        m0_rsp_err   = m0_rsp_valid && rspErr_q;
        m1_rsp_err   = m1_rsp_valid && rspErr_q;
        m0_rsp_rdata = m0_rsp_valid ? rspRdata_q : '0;
        m1_rsp_rdata = m1_rsp_valid ? rspRdata_q : '0;
    end

    // Request latch; strobes are decided here so they are registered and last exactly the ISSUE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant_q <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            inRange_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            memWrite_q  <= 1'b0;
            memRead_q   <= 1'b0;
        end else if (accept) begin
            lastGrant_q <= acceptOwner;
            owner_q     <= acceptOwner;
            we_q        <= reqWe;
            inRange_q   <= reqInRange;
            addr_q      <= reqAddr;
            wdata_q     <= reqWdata;
            memWrite_q  <= reqWe && reqInRange;
            memRead_q   <= !reqWe && reqInRange;
        end else begin
            memWrite_q  <= 1'b0;
            memRead_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end else if (state_q == ISSUE) begin
            rspValid_q <= 1'b1;
            rspErr_q   <= !inRange_q;
            rspRdata_q <= (inRange_q && !we_q) ? mem_data_read : '0;
        end else begin
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRdata_q <= '0;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_data_write = wdata_q;
    assign mem_write      = memWrite_q;
    assign mem_read       = memRead_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: drives both masters against a stand-in data memory and compares against a
// transaction-level reference (round-robin order, 3-cycle cadence, reference memory image).
module tb_dmem_arbiter;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int cyc; int m; } acc_t;
    typedef struct { int cyc; int m; logic [31:0] rdata; logic err; } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req_valid = 1'b0, m0_req_we = 1'b0;
    logic [31:0] m0_req_addr = '0, m0_req_wdata = '0;
    logic        m1_req_valid = 1'b0, m1_req_we = 1'b0;
    logic [31:0] m1_req_addr = '0, m1_req_wdata = '0;
    logic        m0_req_ready, m0_rsp_valid, m0_rsp_err;
    logic        m1_req_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic [31:0] mem_addr, mem_data_write, mem_data_read;
    logic        mem_write, mem_read;

    int errors = 0;
    int checks = 0;
    int modelLast = 1;

    logic [31:0] memArr [0:999];
    logic [31:0] refMem [0:999];
    logic        memReady = 1'b0;

    req_t        q0[$], q1[$];
    acc_t        accLog[$];
    rsp_t        rspLog[$];
    int          ready0Cyc[$];
    logic [31:0] wrAddrLog[$];
    int          wrPulses, rdPulses, strobeBoth, readyBoth;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(1000)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_write(mem_write),
        .mem_read(mem_read), .mem_data_read(mem_data_read)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seedWord(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Stand-in data_memory: combinational read, write on the rising edge
    assign mem_data_read = (mem_read && mem_addr < 32'd1000) ? memArr[mem_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (!memReady) begin
            for (int i = 0; i < 1000; i++) memArr[i] <= seedWord(i);
            memReady <= 1'b1;
        end else if (mem_write && mem_addr < 32'd1000) begin
            memArr[mem_addr[9:0]] <= mem_data_write;
        end
    end

    function automatic req_t mkReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // Reference: an access touches memory only below 1000; reads return the image, writes return 0
    function automatic void modelApply(input req_t r, output logic [31:0] rd, output logic e);
        e  = (r.addr >= 32'd1000);
        rd = 32'h0;
        if (!e) begin
            if (r.we) refMem[r.addr[9:0]] = r.wdata;
            else      rd = refMem[r.addr[9:0]];
        end
    endfunction

    function automatic logic [31:0] randAddr();
        int pick = $urandom_range(0, 9);
        if (pick == 0) return 32'd999;
        if (pick == 1) return 32'd1000;
        if (pick == 2) return 32'hFFFF_FFFF;
        if (pick == 3) return $urandom;
        return $urandom_range(0, 999);
    endfunction

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelLast = 1;
    endtask

    // Streams q0/q1 with valid held while each queue is non-empty and records what was observed
    task automatic runStream(input int maxCyc, output logic timedOut);
        int cyc = 0;
        int tail = 0;
        acc_t a;
        rsp_t r;
        accLog.delete(); rspLog.delete(); ready0Cyc.delete(); wrAddrLog.delete();
        wrPulses = 0; rdPulses = 0; strobeBoth = 0; readyBoth = 0;
        timedOut = 1'b0;
        while (tail < 4) begin
            if (cyc >= maxCyc) begin timedOut = 1'b1; break; end
            @(posedge clk); #1;
            m0_req_valid = (q0.size() > 0);
            if (q0.size() > 0) begin
                m0_req_we = q0[0].we; m0_req_addr = q0[0].addr; m0_req_wdata = q0[0].wdata;
            end
            m1_req_valid = (q1.size() > 0);
            if (q1.size() > 0) begin
                m1_req_we = q1[0].we; m1_req_addr = q1[0].addr; m1_req_wdata = q1[0].wdata;
            end
            @(negedge clk);
            if (m0_req_ready) ready0Cyc.push_back(cyc);
            if (m0_req_ready && m1_req_ready) readyBoth++;
            if (mem_write && mem_read) strobeBoth++;
            if (mem_write) begin wrPulses++; wrAddrLog.push_back(mem_addr); end
            if (mem_read) rdPulses++;
            if (m0_rsp_valid) begin r.cyc = cyc; r.m = 0; r.rdata = m0_rsp_rdata; r.err = m0_rsp_err; rspLog.push_back(r); end
            if (m1_rsp_valid) begin r.cyc = cyc; r.m = 1; r.rdata = m1_rsp_rdata; r.err = m1_rsp_err; rspLog.push_back(r); end
            if (m0_req_valid && m0_req_ready) begin a.cyc = cyc; a.m = 0; accLog.push_back(a); void'(q0.pop_front()); end
            if (m1_req_valid && m1_req_ready) begin a.cyc = cyc; a.m = 1; accLog.push_back(a); void'(q1.pop_front()); end
            if (q0.size() == 0 && q1.size() == 0) tail++;
            cyc++;
        end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err, mem_write, mem_read} !== 6'b0)
            begin errors++; $display("[TB] FAIL reset_flags: got %b required 000000", {m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err, mem_write, mem_read}); end
        checks++;
        if ({mem_addr, mem_data_write, m0_rsp_rdata, m1_rsp_rdata} !== 128'h0)
            begin errors++; $display("[TB] FAIL reset_buses: addr=%h wdata=%h rd0=%h rd1=%h required all 0", mem_addr, mem_data_write, m0_rsp_rdata, m1_rsp_rdata); end
        @(posedge clk); #1 rst = 1'b0;
        modelLast = 1;
        @(negedge clk);
        checks++;
        if ({m0_req_ready, m1_req_ready} !== 2'b00)
            begin errors++; $display("[TB] FAIL reset_idle_ready: got %b required 00", {m0_req_ready, m1_req_ready}); end
    endtask

    task automatic test_write_read();
        logic to;
        logic [31:0] rd;
        logic e;
        req_t w = mkReq(1'b1, 32'd5, 32'hDEAD_BEEF);
        req_t r = mkReq(1'b0, 32'd5, 32'h0);
        q0.delete(); q1.delete();
        q0.push_back(w); q0.push_back(r);
        runStream(60, to);
        modelApply(w, rd, e);
        modelApply(r, rd, e);
        modelLast = 0;
        checks++;
        if (to !== 1'b0 || accLog.size() != 2 || rspLog.size() != 2)
            begin errors++; $display("[TB] FAIL wr_rd_count: timeout=%b acc=%0d rsp=%0d required 0/2/2", to, accLog.size(), rspLog.size()); end
        else begin
            checks++;
            if (wrPulses != 1 || wrAddrLog[0] !== 32'd5)
                begin errors++; $display("[TB] FAIL wr_strobe: pulses=%0d addr=%h required 1/5", wrPulses, wrAddrLog[0]); end
            checks++;
            if (rspLog[0].rdata !== 32'h0 || rspLog[0].err !== 1'b0)
                begin errors++; $display("[TB] FAIL wr_ack: rdata=%h err=%b required 0/0", rspLog[0].rdata, rspLog[0].err); end
            checks++;
            if (rspLog[1].m != 0 || rspLog[1].rdata !== 32'hDEAD_BEEF || rspLog[1].err !== 1'b0)
                begin errors++; $display("[TB] FAIL rd_data: m=%0d rdata=%h err=%b required 0/deadbeef/0", rspLog[1].m, rspLog[1].rdata, rspLog[1].err); end
            checks++;
            if (rspLog[1].cyc - accLog[1].cyc != 2)
                begin errors++; $display("[TB] FAIL rd_latency: got %0d required 2", rspLog[1].cyc - accLog[1].cyc); end
            checks++;
            if (rdPulses != 1 || strobeBoth != 0)
                begin errors++; $display("[TB] FAIL rd_strobe: reads=%0d both=%0d required 1/0", rdPulses, strobeBoth); end
        end
    endtask

    task automatic test_round_robin();
        req_t c0[$], c1[$];
        req_t r;
        logic to, e;
        logic [31:0] rd;
        int i0 = 0, i1 = 0, g;
        applyReset();
        q0.delete(); q1.delete();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mkReq(1'b0, $urandom_range(0, 999), 32'h0));
            q1.push_back(mkReq(1'b0, $urandom_range(0, 999), 32'h0));
        end
        c0 = q0; c1 = q1;
        runStream(100, to);
        checks++;
        if (to !== 1'b0 || accLog.size() != 8 || rspLog.size() != 8 || readyBoth != 0)
            begin errors++; $display("[TB] FAIL rr_count: timeout=%b acc=%0d rsp=%0d bothReady=%0d required 0/8/8/0", to, accLog.size(), rspLog.size(), readyBoth); end
        for (int k = 0; k < accLog.size() && k < rspLog.size() && k < 8; k++) begin
            if (i0 < c0.size() && i1 < c1.size()) g = (modelLast == 0) ? 1 : 0;
            else                                   g = (i0 < c0.size()) ? 0 : 1;
            if (g == 0) begin r = c0[i0]; i0++; end else begin r = c1[i1]; i1++; end
            modelLast = g;
            modelApply(r, rd, e);
            checks++;
            if (accLog[k].m != g || accLog[k].cyc != 3 * k)
                begin errors++; $display("[TB] FAIL rr_grant[%0d]: m=%0d cyc=%0d required %0d/%0d", k, accLog[k].m, accLog[k].cyc, g, 3 * k); end
            checks++;
            if (rspLog[k].m != g || rspLog[k].cyc != 3 * k + 2 || rspLog[k].rdata !== rd || rspLog[k].err !== e)
                begin errors++; $display("[TB] FAIL rr_rsp[%0d]: m=%0d cyc=%0d rdata=%h err=%b required %0d/%0d/%h/%b", k, rspLog[k].m, rspLog[k].cyc, rspLog[k].rdata, rspLog[k].err, g, 3 * k + 2, rd, e); end
        end
    endtask

    task automatic test_out_of_range();
        req_t c1[$];
        logic to, e;
        logic [31:0] rd;
        q0.delete(); q1.delete();
        q1.push_back(mkReq(1'b1, 32'd999, 32'h0000_1234));
        q1.push_back(mkReq(1'b0, 32'd1000, 32'h0));
        q1.push_back(mkReq(1'b1, 32'hFFFF_FFFF, $urandom));
        q1.push_back(mkReq(1'b0, 32'd999, 32'h0));
        c1 = q1;
        runStream(80, to);
        modelLast = 1;
        checks++;
        if (to !== 1'b0 || rspLog.size() != 4)
            begin errors++; $display("[TB] FAIL oor_count: timeout=%b rsp=%0d required 0/4", to, rspLog.size()); end
        checks++;
        if (wrPulses != 1 || rdPulses != 1 || wrAddrLog.size() != 1 || wrAddrLog[0] !== 32'd999)
            begin errors++; $display("[TB] FAIL oor_strobes: writes=%0d reads=%0d required 1/1 at 999", wrPulses, rdPulses); end
        for (int k = 0; k < rspLog.size() && k < 4; k++) begin
            modelApply(c1[k], rd, e);
            checks++;
            if (rspLog[k].m != 1 || rspLog[k].rdata !== rd || rspLog[k].err !== e)
                begin errors++; $display("[TB] FAIL oor_rsp[%0d]: m=%0d rdata=%h err=%b required 1/%h/%b", k, rspLog[k].m, rspLog[k].rdata, rspLog[k].err, rd, e); end
        end
        if (rspLog.size() == 4) begin
            checks++;
            if (rspLog[3].rdata !== 32'h0000_1234 || rspLog[1].err !== 1'b1 || rspLog[2].err !== 1'b1)
                begin errors++; $display("[TB] FAIL oor_preserve: rd999=%h err1=%b err2=%b required 1234/1/1", rspLog[3].rdata, rspLog[1].err, rspLog[2].err); end
        end
    endtask

    task automatic test_held_ready();
        logic to, e;
        logic [31:0] rd;
        int busyReady = 0;
        req_t a = mkReq(1'b0, $urandom_range(0, 999), 32'h0);
        req_t b = mkReq(1'b0, $urandom_range(0, 999), 32'h0);
        q0.delete(); q1.delete();
        q0.push_back(a); q0.push_back(b);
        runStream(40, to);
        modelApply(a, rd, e);
        modelApply(b, rd, e);
        modelLast = 0;
        checks++;
        if (to !== 1'b0 || accLog.size() != 2)
            begin errors++; $display("[TB] FAIL held_count: timeout=%b acc=%0d required 0/2", to, accLog.size()); end
        else begin
            foreach (ready0Cyc[i])
                if (ready0Cyc[i] == accLog[0].cyc + 1 || ready0Cyc[i] == accLog[0].cyc + 2) busyReady++;
            checks++;
            if (accLog[1].cyc - accLog[0].cyc != 3)
                begin errors++; $display("[TB] FAIL held_spacing: got %0d cycles required 3", accLog[1].cyc - accLog[0].cyc); end
            checks++;
            if (busyReady != 0)
                begin errors++; $display("[TB] FAIL held_busy_ready: got %0d high cycles required 0", busyReady); end
        end
    endtask

    task automatic test_reset_in_issue();
        int waited = 0;
        logic sawRsp = 1'b0, sawStrobe = 1'b0;
        logic [31:0] wd = $urandom;
        @(posedge clk); #1;
        m0_req_valid = 1'b1; m0_req_we = 1'b1; m0_req_addr = 32'd7; m0_req_wdata = wd;
        @(negedge clk);
        while (!m0_req_ready && waited < 10) begin @(negedge clk); waited++; end
        checks++;
        if (m0_req_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL rii_accept: ready=%b after %0d cycles required 1", m0_req_ready, waited); end
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_addr !== 32'd7)
            begin errors++; $display("[TB] FAIL rii_issue: mem_write=%b addr=%h required 1/7", mem_write, mem_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        modelLast = 1;
        refMem[7] = wd;  // the memory still saw the strobe on the edge that sampled reset
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (m0_rsp_valid || m1_rsp_valid) sawRsp = 1'b1;
            if (mem_write || mem_read) sawStrobe = 1'b1;
        end
        checks++;
        if (sawRsp !== 1'b0 || sawStrobe !== 1'b0)
            begin errors++; $display("[TB] FAIL rii_dropped: rsp=%b strobe=%b required 0/0", sawRsp, sawStrobe); end
        @(posedge clk); #1;
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 32'd0;
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = 32'd0;
        @(negedge clk);
        checks++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10)
            begin errors++; $display("[TB] FAIL rii_tie: ready=%b required 10", {m0_req_ready, m1_req_ready}); end
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_boundary();
        logic to, e;
        logic [31:0] rd;
        req_t w = mkReq(1'b1, 32'd999, 32'hA5A5_A5A5);
        req_t r = mkReq(1'b0, 32'd999, 32'h0);
        q0.delete(); q1.delete();
        q0.push_back(w); q0.push_back(r);
        runStream(40, to);
        modelApply(w, rd, e);
        modelApply(r, rd, e);
        modelLast = 0;
        checks++;
        if (to !== 1'b0 || rspLog.size() != 2)
            begin errors++; $display("[TB] FAIL bnd_count: timeout=%b rsp=%0d required 0/2", to, rspLog.size()); end
        else begin
            checks++;
            if (rspLog[1].rdata !== 32'hA5A5_A5A5 || rspLog[1].err !== 1'b0)
                begin errors++; $display("[TB] FAIL bnd_read999: rdata=%h err=%b required a5a5a5a5/0", rspLog[1].rdata, rspLog[1].err); end
        end
    endtask

    task automatic test_random();
        req_t c0[$], c1[$];
        req_t r;
        logic to, e;
        logic [31:0] rd;
        int i0, i1, g, n0, n1;
        for (int round = 0; round < 4; round++) begin
            q0.delete(); q1.delete();
            n0 = $urandom_range(0, 6);
            n1 = $urandom_range(1, 6);
            for (int k = 0; k < n0; k++) q0.push_back(mkReq(1'($urandom_range(0, 1)), randAddr(), $urandom));
            for (int k = 0; k < n1; k++) q1.push_back(mkReq(1'($urandom_range(0, 1)), randAddr(), $urandom));
            c0 = q0; c1 = q1;
            i0 = 0; i1 = 0;
            runStream(200, to);
            checks++;
            if (to !== 1'b0 || accLog.size() != n0 + n1 || rspLog.size() != n0 + n1 || strobeBoth != 0)
                begin errors++; $display("[TB] FAIL rnd_count[%0d]: timeout=%b acc=%0d rsp=%0d both=%0d required 0/%0d/%0d/0", round, to, accLog.size(), rspLog.size(), strobeBoth, n0 + n1, n0 + n1); end
            for (int k = 0; k < accLog.size() && k < rspLog.size() && k < n0 + n1; k++) begin
                if (i0 < n0 && i1 < n1) g = (modelLast == 0) ? 1 : 0;
                else                    g = (i0 < n0) ? 0 : 1;
                if (g == 0) begin r = c0[i0]; i0++; end else begin r = c1[i1]; i1++; end
                modelLast = g;
                modelApply(r, rd, e);
                checks++;
                if (accLog[k].m != g || accLog[k].cyc != 3 * k || rspLog[k].m != g || rspLog[k].cyc != 3 * k + 2
                    || rspLog[k].rdata !== rd || rspLog[k].err !== e)
                    begin errors++; $display("[TB] FAIL rnd_txn[%0d.%0d]: acc m=%0d cyc=%0d rsp m=%0d cyc=%0d rdata=%h err=%b required m=%0d acc=%0d rsp=%0d rdata=%h err=%b",
                        round, k, accLog[k].m, accLog[k].cyc, rspLog[k].m, rspLog[k].cyc, rspLog[k].rdata, rspLog[k].err, g, 3 * k, 3 * k + 2, rd, e); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1000; i++) refMem[i] = seedWord(i);
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_held_ready();
        test_reset_in_issue();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
